pll_dyn_div_ctrl: RTL

- Sequencer that drives the dynamic divider inputs (FBDSEL/IDSEL) and RESET of a Gowin PLLVR/rPLL wrapper, and monitors its LOCK output.
- Accepts a new feedback/input divider pair over a valid/ready handshake. It applies the new code, pulses PLL reset, then waits for a stable lock or a timeout.
- Sits beside the PLL wrapper and is clocked from the same free-running reference clock that feeds the PLL CLKIN.

---
 rtl/pll_ctrl_pkg.sv | 18 +
 rtl/pll_lock_sync.sv | 43 ++++
 rtl/pll_dyn_div_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the Gowin PLL dynamic-divider controller.
package pll_ctrl_pkg;

  localparam int unsigned DIV_W = 6;

  typedef enum logic [1:0] {
    RST_HOLD,
    WAIT_LOCK,
    READY,
    FAIL
  } state_t;

  // The PLL FBDSEL/IDSEL pins take the bitwise inverse of the select value.
  function automatic logic [DIV_W-1:0] div_code(input logic [DIV_W-1:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Brings the asynchronous PLL LOCK into the clkin domain and qualifies it:
// lock_stable_o rises once lock_s has been high for LOCK_STABLE consecutive
// counting cycles.
module pll_lock_sync #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_STABLE = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic clr_i,
  output logic lock_s_o,
  output logic lock_stable_o
);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] stab_q;
  logic             stable_q;

  // Two-flop synchronizer, stability counter and registered stable flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stab_q   <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q <= lock_i;
      sync_q <= meta_q;
      if (clr_i || !sync_q) begin
        stab_q <= '0;
      end else if (stab_q != CNT_W'(LOCK_STABLE)) begin
        stab_q <= stab_q + CNT_W'(1);
      end
      stable_q <= !clr_i && (stab_q == CNT_W'(LOCK_STABLE));
    end
  end

  assign lock_s_o      = sync_q;
  assign lock_stable_o = stable_q;

endmodule

// File: rtl/pll_dyn_div_ctrl.sv
// Dynamic divider sequencer for a Gowin PLLVR/rPLL: applies new FBDSEL/IDSEL
// codes, pulses PLL reset, then waits for a stable lock or a timeout.
module pll_dyn_div_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FBDIV_INIT   = 12,
  parameter int unsigned IDIV_INIT    = 5
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_fbdiv,
  input  logic [DIV_W-1:0] req_idiv,
  output logic [DIV_W-1:0] fdiv,
  output logic [DIV_W-1:0] idiv,
  output logic             pll_reset,
  input  logic             lock_i,
  output logic             locked,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             lost
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] fdiv_q, fdiv_d;
  logic [DIV_W-1:0] idiv_q, idiv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;
  logic             lock_s;
  logic             lock_stable;
  logic             accept;

  pll_lock_sync #(
    .CNT_W      (CNT_W),
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_sync (
    .clk_i        (clkin),
    .rst_i        (reset),
    .lock_i       (lock_i),
    .clr_i        (state_q != WAIT_LOCK),
    .lock_s_o     (lock_s),
    .lock_stable_o(lock_stable)
  );

  // Level outputs are pure functions of the registered state.
  assign pll_reset = (state_q == RST_HOLD);
  assign busy      = (state_q == RST_HOLD) || (state_q == WAIT_LOCK);
  assign req_ready = (state_q == READY) || (state_q == FAIL);
  assign locked    = (state_q == READY);
  assign accept    = req_valid && req_ready;

  assign fdiv = fdiv_q;
  assign idiv = idiv_q;
  assign done = done_q;
  assign err  = err_q;
  assign lost = lost_q;

  // State register plus registered divider codes and event pulses.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      fdiv_q  <= div_code(DIV_W'(FBDIV_INIT));
      idiv_q  <= div_code(DIV_W'(IDIV_INIT));
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdiv_q  <= fdiv_d;
      idiv_q  <= idiv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state logic; one counter is shared by the reset hold and the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fdiv_d  = fdiv_q;
    idiv_d  = idiv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lost_d  = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so it wins a tie with the timeout.
        if (lock_stable) begin
          cnt_d   = '0;
          state_d = READY;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = FAIL;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        // A request arriving with lock loss is taken and masks the lost pulse.
        if (!accept && !lock_s) begin
          cnt_d   = '0;
          state_d = RST_HOLD;
          lost_d  = 1'b1;
        end
      end
      FAIL: begin
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      fdiv_d  = div_code(req_fbdiv);
      idiv_d  = div_code(req_idiv);
      cnt_d   = '0;
      state_d = RST_HOLD;
    end
  end

endmodule
